mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Shares one blocking memory port between the instruction-fetch requester (IF) and the load/store requester (LS) of the 5-stage pipeline. Accepts at most one request at a time, forwards it to the memory port, waits for the response, and routes the response back to the requester that issued it. Sits between IF_stage/ls_stage and the single memory/bus interface. Its ready/response signals are the stall sources for the pipeline's hazard logic.

## Interface
- XLEN, 64, address and data width
- MASK_W, XLEN/8, byte write-mask width
---
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- if_req_valid  in  1  IF read request
- if_req_addr  in  XLEN  IF fetch address
- if_req_ready  out  1  IF request accepted this cycle
- if_kill  in  1  IF flush; drops the IF response of the in-flight IF transaction
- if_resp_valid  out  1  one-cycle pulse, IF read data valid
- if_resp_data  out  XLEN  IF read data
- ls_req_valid, ls_req_wen  in  1  LS request; write when wen=1
- ls_req_addr, ls_req_wdata  in  XLEN  LS address / write data
- ls_req_wmask  in  MASK_W  LS byte enables
- ls_req_ready  out  1  LS request accepted this cycle
- ls_resp_valid  out  1  one-cycle pulse, LS read data valid or write ack
- ls_resp_data  out  XLEN  LS read data (0 for writes)
- mem_req_valid  out  1  memory request
- mem_req_ready  in  1  memory accepts request
- mem_req_addr, mem_req_wdata  out  XLEN  registered request fields
- mem_req_wen  out  1, mem_req_wmask  out  MASK_W
- mem_resp_valid  in  1  memory response, also returned for writes
- mem_resp_rdata  in  XLEN  memory read data
- busy  out  1  state != IDLE
- spurious_resp  out  1  sticky: mem_resp_valid seen outside RESP

## Operation
- FSM: IDLE, REQ, RESP. Reset state IDLE.
- IDLE: if any req_valid, pick a winner. Assert that requester's req_ready combinationally, latch its addr/wdata/wmask/wen (IF: wen=0, wmask=0) and grant ID, then go to REQ. The loser's ready stays 0.
- Priority: LS over IF when both are valid (the default).
- REQ: mem_req_valid=1 with latched fields. Go to RESP on mem_req_ready.
- RESP: on mem_resp_valid, pulse the granted requester's resp_valid for that cycle only, then go to IDLE. resp_data is mem_resp_rdata passed through combinationally. ls_resp_data is 0 on writes.
- if_kill while IF is granted (REQ or RESP), or in the same cycle as the IF acceptance: set a kill flag. The bus transaction still completes, but if_resp_valid is suppressed. The flag clears on return to IDLE.
- mem_resp_valid in IDLE or REQ: ignored, and spurious_resp is set. Only rst clears spurious_resp.
- Requesters hold valid and fields stable until ready. Dropping valid before ready is legal; no request is then issued.
- rst mid-operation: immediately go to IDLE, mem_req_valid=0, kill flag cleared. A late memory response arriving afterwards sets spurious_resp.
- Reset values: all outputs 0, except the combinational readies, which follow IDLE arbitration.

## Timing
- Acceptance at cycle N (IDLE). mem_req_valid from N+1.
- Earliest response: mem_req_ready at N+1, mem_resp_valid at N+2, resp_valid at N+2, next acceptance at N+3.
- Throughput: at most one transaction per 3 cycles.
- No combinational path from mem_* inputs to mem_* outputs. mem_resp to resp_valid/data is combinational.
- Readies are asserted only in IDLE. They never depend on mem_req_ready.

## Configuration
- ARB_ROUND_ROBIN_EN defined: when both requesters are valid, grant the one not granted last. The last-grant register resets to LS, so IF wins the first tie. A single valid requester always wins.
- Undefined: fixed priority LS > IF, and the last-grant register is absent.

## Structure
- Shared package mem_arb_pkg holds:
  - the state enum (IDLE/REQ/RESP);
  - the grant encoding GNT_IF=0, GNT_LS=1;
  - XLEN/MASK_W defaults.
- One sub-module, mem_arb_pick: combinational winner selection (fixed or round-robin) from the two valids and the last grant.
- The top holds the FSM, latched fields, kill flag and sticky error.

## Test plan
- IF only, addr 0x8000_0000, memory ready at once and responds next cycle with 0x13 -> if_resp_valid pulses at N+2 with 0x13; busy is low at N+3.
- IF and LS valid together, LS write addr 0x100, wdata 0xAA, wmask 0x01:
  - default build: ls_req_ready=1, IF waits, then IF is granted in the following IDLE;
  - with ARB_ROUND_ROBIN_EN: IF is granted first.
- mem_req_ready held low 5 cycles -> mem_req_valid and fields stay stable for 6 cycles; no resp_valid.
- if_kill pulsed in RESP of an IF read -> the transaction completes, if_resp_valid stays 0, and the next request is accepted normally.
- rst asserted in REQ, then mem_resp_valid arrives 2 cycles after release -> outputs 0 during reset, no resp pulse, spurious_resp=1.
- LS read from 0x200 returning 0xDEAD_BEEF -> ls_resp_data=0xDEAD_BEEF for one cycle. A write returns ls_resp_data=0.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg
//   Shared definitions for the IF/LS memory-port arbiter:
//   - arb_state_e : arbiter FSM states (IDLE / REQ / RESP)
//   - gnt_e       : grant encoding (GNT_IF = 0, GNT_LS = 1)
//   - XLEN_DEF / MASK_W_DEF : default data/address and byte-mask widths
package mem_arb_pkg;

  localparam int unsigned XLEN_DEF   = 64;
  localparam int unsigned MASK_W_DEF = XLEN_DEF / 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } arb_state_e;

  typedef enum logic {
    GNT_IF = 1'b0,
    GNT_LS = 1'b1
  } gnt_e;

endpackage

// File: rtl/mem_arb_pick.sv
// mem_arb_pick
//   Combinational winner selection between the instruction-fetch (IF) and
//   load/store (LS) requesters.
//   Build option ARB_ROUND_ROBIN_EN:
//     defined   - on a tie, grant the requester not granted last (last_gnt)
//     undefined - fixed priority LS > IF; last_gnt port is absent
//   A single valid requester always wins. With no valid requester the
//   output is GNT_LS and is meaningless (callers gate it with the valids).
//
//   Ports:
//     if_valid  in   IF request valid
//     ls_valid  in   LS request valid
//     last_gnt  in   previous grant (round-robin build only)
//     gnt       out  selected requester
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic if_valid,
  input  logic ls_valid,
`ifdef ARB_ROUND_ROBIN_EN
  input  gnt_e last_gnt,
`endif
  output gnt_e gnt
);

  always_comb begin
    gnt = GNT_LS;
    if (if_valid && ls_valid) begin
`ifdef ARB_ROUND_ROBIN_EN
      gnt = (last_gnt == GNT_LS) ? GNT_IF : GNT_LS;
`else
      gnt = GNT_LS;
`endif
    end else if (if_valid) begin
      gnt = GNT_IF;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one blocking memory port between the IF and LS requesters of the
//   pipeline. One transaction at a time: accept (IDLE) -> present request
//   (REQ) -> wait for response (RESP) -> route response to the granted
//   requester. Readies and response valids are the pipeline stall sources.
//
//   Build option ARB_ROUND_ROBIN_EN: round-robin tie-break with a last-grant
//   register (resets to LS, so IF wins the first tie). Undefined: fixed
//   priority LS > IF.
//
//   Ports:
//     clk, rst              clock; asynchronous active-high reset
//     if_req_*              IF read request (valid/addr) and ready
//     if_kill               flush: suppress the response of the IF transaction
//     if_resp_valid/data    one-cycle IF read response
//     ls_req_*              LS request (valid/wen/addr/wdata/wmask) and ready
//     ls_resp_valid/data    one-cycle LS response (data 0 for writes)
//     mem_req_*             registered request to the memory port
//     mem_resp_valid/rdata  memory response (also returned for writes)
//     busy                  FSM not in IDLE
//     spurious_resp         sticky: memory response seen outside RESP
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned XLEN   = XLEN_DEF,
  parameter int unsigned MASK_W = XLEN / 8
) (
  input  logic              clk,
  input  logic              rst,
  // instruction fetch
  input  logic              if_req_valid,
  input  logic [XLEN-1:0]   if_req_addr,
  output logic              if_req_ready,
  input  logic              if_kill,
  output logic              if_resp_valid,
  output logic [XLEN-1:0]   if_resp_data,
  // load / store
  input  logic              ls_req_valid,
  input  logic              ls_req_wen,
  input  logic [XLEN-1:0]   ls_req_addr,
  input  logic [XLEN-1:0]   ls_req_wdata,
  input  logic [MASK_W-1:0] ls_req_wmask,
  output logic              ls_req_ready,
  output logic              ls_resp_valid,
  output logic [XLEN-1:0]   ls_resp_data,
  // memory port
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [XLEN-1:0]   mem_req_addr,
  output logic [XLEN-1:0]   mem_req_wdata,
  output logic              mem_req_wen,
  output logic [MASK_W-1:0] mem_req_wmask,
  input  logic              mem_resp_valid,
  input  logic [XLEN-1:0]   mem_resp_rdata,
  // status
  output logic              busy,
  output logic              spurious_resp
);

  arb_state_e        state_q, state_d;
  gnt_e              gnt_q, gnt_d;
  logic [XLEN-1:0]   addr_q, addr_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;
  logic [MASK_W-1:0] wmask_q, wmask_d;
  logic              wen_q, wen_d;
  logic              kill_q, kill_d;
  logic              spurious_q, spurious_d;
  gnt_e              pick_gnt;
  logic              resp_fire;

`ifdef ARB_ROUND_ROBIN_EN
  gnt_e              last_gnt_q, last_gnt_d;
`endif

  mem_arb_pick u_pick (
    .if_valid (if_req_valid),
    .ls_valid (ls_req_valid),
`ifdef ARB_ROUND_ROBIN_EN
    .last_gnt (last_gnt_q),
`endif
    .gnt      (pick_gnt)
  );

  // Readies depend only on state and requester valids, never on mem_* inputs.
  always_comb begin
    if_req_ready = 1'b0;
    ls_req_ready = 1'b0;
    if (state_q == IDLE) begin
      if_req_ready = if_req_valid && (pick_gnt == GNT_IF);
      ls_req_ready = ls_req_valid && (pick_gnt == GNT_LS);
    end
  end

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wmask_d    = wmask_q;
    wen_d      = wen_q;
    kill_d     = kill_q;
    spurious_d = spurious_q | (mem_resp_valid && (state_q != RESP));
`ifdef ARB_ROUND_ROBIN_EN
    last_gnt_d = last_gnt_q;
`endif

    // A flush while IF owns the port only hides its response; the bus
    // transaction itself always runs to completion.
    if ((state_q != IDLE) && (gnt_q == GNT_IF) && if_kill) begin
      kill_d = 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        kill_d = 1'b0;
        if (ls_req_ready) begin
          state_d = REQ;
          gnt_d   = GNT_LS;
          addr_d  = ls_req_addr;
          wdata_d = ls_req_wdata;
          wmask_d = ls_req_wmask;
          wen_d   = ls_req_wen;
`ifdef ARB_ROUND_ROBIN_EN
          last_gnt_d = GNT_LS;
`endif
        end else if (if_req_ready) begin
          state_d = REQ;
          gnt_d   = GNT_IF;
          addr_d  = if_req_addr;
          wdata_d = '0;
          wmask_d = '0;
          wen_d   = 1'b0;
          kill_d  = if_kill;
`ifdef ARB_ROUND_ROBIN_EN
          last_gnt_d = GNT_IF;
`endif
        end
      end
      REQ: begin
        if (mem_req_ready) begin
          state_d = RESP;
        end
      end
      RESP: begin
        if (mem_resp_valid) begin
          state_d = IDLE;
          kill_d  = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        kill_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      gnt_q      <= GNT_IF;
      addr_q     <= '0;
      wdata_q    <= '0;
      wmask_q    <= '0;
      wen_q      <= 1'b0;
      kill_q     <= 1'b0;
      spurious_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      wmask_q    <= wmask_d;
      wen_q      <= wen_d;
      kill_q     <= kill_d;
      spurious_q <= spurious_d;
    end
  end

`ifdef ARB_ROUND_ROBIN_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_gnt_q <= GNT_LS;
    end else begin
      last_gnt_q <= last_gnt_d;
    end
  end
`endif

  // Response path is combinational from mem_resp_*; data is zeroed whenever
  // its valid is low, and for LS writes.
  always_comb begin
    resp_fire     = (state_q == RESP) && mem_resp_valid;
    if_resp_valid = resp_fire && (gnt_q == GNT_IF) && !kill_q;
    ls_resp_valid = resp_fire && (gnt_q == GNT_LS);
    if_resp_data  = if_resp_valid ? mem_resp_rdata : '0;
    ls_resp_data  = (ls_resp_valid && !wen_q) ? mem_resp_rdata : '0;
  end

  always_comb begin
    mem_req_valid = (state_q == REQ);
    mem_req_addr  = addr_q;
    mem_req_wdata = wdata_q;
    mem_req_wmask = wmask_q;
    mem_req_wen   = wen_q;
    busy          = (state_q != IDLE);
    spurious_resp = spurious_q;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
`timescale 1ns/1ps
// tb_mem_port_arbiter
//   Directed scenarios plus randomized traffic, checked against a
//   transaction-level reference model of the arbiter.
//   Build option ARB_ROUND_ROBIN_EN selects the round-robin tie expectations.
module tb_mem_port_arbiter;

  localparam int unsigned XLEN   = 64;
  localparam int unsigned MASK_W = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              if_req_valid = 1'b0;
  logic [XLEN-1:0]   if_req_addr = '0;
  logic              if_req_ready;
  logic              if_kill = 1'b0;
  logic              if_resp_valid;
  logic [XLEN-1:0]   if_resp_data;
  logic              ls_req_valid = 1'b0;
  logic              ls_req_wen = 1'b0;
  logic [XLEN-1:0]   ls_req_addr = '0;
  logic [XLEN-1:0]   ls_req_wdata = '0;
  logic [MASK_W-1:0] ls_req_wmask = '0;
  logic              ls_req_ready;
  logic              ls_resp_valid;
  logic [XLEN-1:0]   ls_resp_data;
  logic              mem_req_valid;
  logic              mem_req_ready = 1'b0;
  logic [XLEN-1:0]   mem_req_addr;
  logic [XLEN-1:0]   mem_req_wdata;
  logic              mem_req_wen;
  logic [MASK_W-1:0] mem_req_wmask;
  logic              mem_resp_valid = 1'b0;
  logic [XLEN-1:0]   mem_resp_rdata = '0;
  logic              busy;
  logic              spurious_resp;

  always #5 clk = ~clk;

  mem_port_arbiter #(.XLEN(XLEN), .MASK_W(MASK_W)) dut (
    .clk            (clk),
    .rst            (rst),
    .if_req_valid   (if_req_valid),
    .if_req_addr    (if_req_addr),
    .if_req_ready   (if_req_ready),
    .if_kill        (if_kill),
    .if_resp_valid  (if_resp_valid),
    .if_resp_data   (if_resp_data),
    .ls_req_valid   (ls_req_valid),
    .ls_req_wen     (ls_req_wen),
    .ls_req_addr    (ls_req_addr),
    .ls_req_wdata   (ls_req_wdata),
    .ls_req_wmask   (ls_req_wmask),
    .ls_req_ready   (ls_req_ready),
    .ls_resp_valid  (ls_resp_valid),
    .ls_resp_data   (ls_resp_data),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_addr   (mem_req_addr),
    .mem_req_wdata  (mem_req_wdata),
    .mem_req_wen    (mem_req_wen),
    .mem_req_wmask  (mem_req_wmask),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_rdata (mem_resp_rdata),
    .busy           (busy),
    .spurious_resp  (spurious_resp)
  );

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: one outstanding transaction, described by who owns it,
  // its fields, whether memory has taken it, and whether it was flushed.
  bit          m_pend = 0;
  bit          m_issued = 0;
  bit          m_kill = 0;
  bit          m_spur = 0;
  bit          m_who_ls = 0;
  bit          m_last_ls = 1;
  logic [63:0] m_addr = '0;
  logic [63:0] m_wdata = '0;
  logic [7:0]  m_wmask = '0;
  bit          m_wen = 0;

  function automatic bit pick_ls(bit iv, bit lv);
`ifdef ARB_ROUND_ROBIN_EN
    if (iv && lv) return !m_last_ls;
`endif
    return lv;
  endfunction

  // Called right after a falling edge with inputs already driven: settle,
  // compare every output with the model, then advance the model by one edge.
  task automatic eval();
    bit          e_ifr, e_lsr, e_ifv, e_lsv, win_ls, acc, resp, e_mv;
    logic [63:0] e_ifd, e_lsd;
    #1;
    if (rst) begin
      m_pend = 0; m_issued = 0; m_kill = 0; m_spur = 0; m_last_ls = 1;
    end
    e_ifr = 0; e_lsr = 0; acc = 0; win_ls = 0;
    if (!m_pend && (if_req_valid || ls_req_valid)) begin
      win_ls = pick_ls(if_req_valid, ls_req_valid);
      e_lsr  = win_ls;
      e_ifr  = !win_ls;
      acc    = !rst;
    end
    resp  = m_pend && m_issued && mem_resp_valid;
    e_ifv = resp && !m_who_ls && !m_kill;
    e_lsv = resp && m_who_ls;
    e_ifd = e_ifv ? mem_resp_rdata : 64'd0;
    e_lsd = (e_lsv && !m_wen) ? mem_resp_rdata : 64'd0;
    e_mv  = m_pend && !m_issued;

    check("if_req_ready", if_req_ready, e_ifr);
    check("ls_req_ready", ls_req_ready, e_lsr);
    check("mem_req_valid", mem_req_valid, e_mv);
    if (e_mv) begin
      check("mem_req_addr", mem_req_addr, m_addr);
      check("mem_req_wdata", mem_req_wdata, m_wdata);
      check("mem_req_wmask", mem_req_wmask, m_wmask);
      check("mem_req_wen", mem_req_wen, m_wen);
    end
    check("if_resp_valid", if_resp_valid, e_ifv);
    check("if_resp_data", if_resp_data, e_ifd);
    check("ls_resp_valid", ls_resp_valid, e_lsv);
    check("ls_resp_data", ls_resp_data, e_lsd);
    check("busy", busy, m_pend);
    check("spurious_resp", spurious_resp, m_spur);

    if (!rst) begin
      if (mem_resp_valid && !(m_pend && m_issued)) m_spur = 1;
      if (m_pend) begin
        if (!m_who_ls && if_kill) m_kill = 1;
        if (resp) m_pend = 0;
        else if (!m_issued && mem_req_ready) m_issued = 1;
      end else if (acc) begin
        m_pend    = 1;
        m_issued  = 0;
        m_who_ls  = win_ls;
        m_last_ls = win_ls;
        m_addr    = win_ls ? ls_req_addr : if_req_addr;
        m_wdata   = win_ls ? ls_req_wdata : 64'd0;
        m_wmask   = win_ls ? ls_req_wmask : 8'd0;
        m_wen     = win_ls ? ls_req_wen : 1'b0;
        m_kill    = !win_ls && if_kill;
      end
    end
  endtask

  task automatic nxt();
    @(negedge clk);
  endtask

  task automatic do_reset();
    if_req_valid = 0; ls_req_valid = 0; if_kill = 0;
    mem_req_ready = 0; mem_resp_valid = 0;
    rst = 1;
    eval(); nxt();
    eval(); nxt();
    rst = 0;
    eval(); nxt();
  endtask

  // Memory always ready and answers the cycle after; requesters drop valid
  // after their ready. Records the cycle of each acceptance (-1 if none).
  task automatic serve(input int max_cycles, output int if_at, output int ls_at);
    bit got_if, got_ls;
    if_at = -1; ls_at = -1;
    for (int c = 0; c < max_cycles; c++) begin
      mem_req_ready  = 1;
      mem_resp_valid = m_pend && m_issued;
      mem_resp_rdata = {$urandom, $urandom};
      eval();
      got_if = if_req_ready;
      got_ls = ls_req_ready;
      if (got_if && if_at < 0) if_at = c;
      if (got_ls && ls_at < 0) ls_at = c;
      nxt();
      if (got_if) if_req_valid = 0;
      if (got_ls) ls_req_valid = 0;
      mem_resp_valid = 0;
      if (!if_req_valid && !ls_req_valid && !m_pend) return;
    end
    check("serve_timeout", 1'b0, 1'b1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int if_at, ls_at;
    bit if_acc, ls_acc;
    #1 rst = 1;
    @(negedge clk);
    do_reset();
    check("rst_busy", busy, 1'b0);

    // Tie between IF read and LS write
    if_req_valid = 1; if_req_addr = 64'h1000;
    ls_req_valid = 1; ls_req_wen = 1; ls_req_addr = 64'h100;
    ls_req_wdata = 64'hAA; ls_req_wmask = 8'h01;
    serve(20, if_at, ls_at);
`ifdef ARB_ROUND_ROBIN_EN
    check("tie_if_first", if_at, 0);
    check("tie_ls_next", ls_at, 3);
`else
    check("tie_ls_first", ls_at, 0);
    check("tie_if_next", if_at, 3);
`endif

    // IF only, earliest response
    if_req_valid = 1; if_req_addr = 64'h8000_0000; mem_req_ready = 1;
    eval(); check("t1_accept", if_req_ready, 1'b1); nxt();
    if_req_valid = 0;
    eval(); check("t1_memreq", mem_req_valid, 1'b1);
    check("t1_addr", mem_req_addr, 64'h8000_0000); nxt();
    mem_resp_valid = 1; mem_resp_rdata = 64'h13;
    eval(); check("t1_resp", if_resp_valid, 1'b1);
    check("t1_data", if_resp_data, 64'h13); nxt();
    mem_resp_valid = 0;
    eval(); check("t1_idle", busy, 1'b0); nxt();

    // Memory stalls 5 cycles
    ls_req_valid = 1; ls_req_wen = 0; ls_req_addr = 64'h300; mem_req_ready = 0;
    eval(); nxt();
    ls_req_valid = 0;
    for (int i = 0; i < 5; i++) begin
      eval(); check("t3_stall_valid", mem_req_valid, 1'b1);
      check("t3_stall_addr", mem_req_addr, 64'h300); nxt();
    end
    mem_req_ready = 1;
    eval(); check("t3_sixth_valid", mem_req_valid, 1'b1); nxt();
    mem_req_ready = 0; mem_resp_valid = 1; mem_resp_rdata = 64'h55;
    eval(); check("t3_resp", ls_resp_valid, 1'b1); nxt();
    mem_resp_valid = 0;

    // Kill in RESP of an IF read
    if_req_valid = 1; if_req_addr = 64'h8000_0040; mem_req_ready = 1;
    eval(); nxt();
    if_req_valid = 0;
    eval(); nxt();
    if_kill = 1;
    eval(); nxt();
    if_kill = 0; mem_resp_valid = 1; mem_resp_rdata = 64'h77;
    eval(); check("t4_killed", if_resp_valid, 1'b0);
    check("t4_busy", busy, 1'b1); nxt();
    mem_resp_valid = 0; if_req_valid = 1; if_req_addr = 64'h8000_0044;
    eval(); check("t4_next_accept", if_req_ready, 1'b1); nxt();
    if_req_valid = 0;
    eval(); nxt();
    mem_resp_valid = 1; mem_resp_rdata = 64'h99;
    eval(); check("t4_next_resp", if_resp_valid, 1'b1);
    check("t4_next_data", if_resp_data, 64'h99); nxt();
    mem_resp_valid = 0;

    // LS read data, then LS write returns zero data
    ls_req_valid = 1; ls_req_wen = 0; ls_req_addr = 64'h200;
    eval(); nxt();
    ls_req_valid = 0;
    eval(); nxt();
    mem_resp_valid = 1; mem_resp_rdata = 64'hDEAD_BEEF;
    eval(); check("t6_rd_valid", ls_resp_valid, 1'b1);
    check("t6_rd_data", ls_resp_data, 64'hDEAD_BEEF); nxt();
    mem_resp_valid = 0;
    eval(); check("t6_rd_pulse", ls_resp_valid, 1'b0); nxt();
    ls_req_valid = 1; ls_req_wen = 1; ls_req_addr = 64'h208;
    ls_req_wdata = 64'h1234; ls_req_wmask = 8'hFF;
    eval(); check("t6_wr_accept", ls_req_ready, 1'b1); nxt();
    ls_req_valid = 0;
    eval(); check("t6_wr_wen", mem_req_wen, 1'b1); nxt();
    mem_resp_valid = 1; mem_resp_rdata = 64'hFFFF_FFFF;
    eval(); check("t6_wr_ack", ls_resp_valid, 1'b1);
    check("t6_wr_data", ls_resp_data, 64'h0); nxt();
    mem_resp_valid = 0;

    // Reset during REQ, late response afterwards
    ls_req_valid = 1; ls_req_wen = 1; ls_req_addr = 64'h400; mem_req_ready = 0;
    eval(); nxt();
    ls_req_valid = 0;
    eval(); check("t5_in_req", mem_req_valid, 1'b1); nxt();
    rst = 1;
    eval(); check("t5_rst_memvalid", mem_req_valid, 1'b0);
    check("t5_rst_busy", busy, 1'b0); nxt();
    eval(); nxt();
    rst = 0;
    eval(); nxt();
    eval(); nxt();
    mem_resp_valid = 1; mem_resp_rdata = 64'h5A5A;
    eval(); check("t5_no_resp", ls_resp_valid, 1'b0); nxt();
    mem_resp_valid = 0;
    eval(); check("t5_spurious", spurious_resp, 1'b1); nxt();
    eval(); check("t5_sticky", spurious_resp, 1'b1); nxt();

    do_reset();
    check("rst_clears_spurious", spurious_resp, 1'b0);

    // Randomized traffic
    if_acc = 0; ls_acc = 0;
    for (int c = 0; c < 3000; c++) begin
      if (if_acc) if_req_valid = 0;
      if (ls_acc) ls_req_valid = 0;
      if (!if_req_valid) begin
        if ($urandom_range(0, 9) < 4) begin
          if_req_valid = 1;
          if_req_addr  = {$urandom, $urandom};
        end
      end else if ($urandom_range(0, 19) == 0) begin
        if_req_valid = 0;
      end
      if (!ls_req_valid) begin
        if ($urandom_range(0, 9) < 4) begin
          ls_req_valid = 1;
          ls_req_wen   = 1'($urandom_range(0, 1));
          ls_req_addr  = {$urandom, $urandom};
          ls_req_wdata = {$urandom, $urandom};
          ls_req_wmask = 8'($urandom);
        end
      end else if ($urandom_range(0, 19) == 0) begin
        ls_req_valid = 0;
      end
      mem_req_ready  = 1'($urandom_range(0, 1));
      mem_resp_valid = m_pend && m_issued && ($urandom_range(0, 1) == 1);
      mem_resp_rdata = {$urandom, $urandom};
      if_kill        = !mem_resp_valid && ($urandom_range(0, 9) == 0);
      eval();
      if_acc = if_req_ready;
      ls_acc = ls_req_ready;
      nxt();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
